// File: rtl/cache_fill_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cache_pkg
// Purpose  : Shared constants and state encoding for the cache miss/fill
//            controller (block geometry, block-alignment mask, FSM states,
//            memory latency of the shared main memory).
// Ports    : n/a (package)
// Revision : 1.0  initial release
// ============================================================================
package cache_pkg;

    // 16-bit words per cache block and the mask that aligns a byte address
    // to the start of its 16-byte block.
    localparam int          BLOCK_WORDS = 8;
    localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;

    // Cycles from a memory read request to its returned word. The controller
    // never counts this itself; it only reacts to mem_data_valid.
    localparam int          MEM_LATENCY = 4;

    // State encoding
    localparam logic [2:0]  ST_IDLE_ENC   = 3'd0;
    localparam logic [2:0]  ST_FILL_I_ENC = 3'd1;
    localparam logic [2:0]  ST_FILL_D_ENC = 3'd2;
    localparam logic [2:0]  ST_DONE_I_ENC = 3'd3;
    localparam logic [2:0]  ST_DONE_D_ENC = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_FILL_I = ST_FILL_I_ENC,
        ST_FILL_D = ST_FILL_D_ENC,
        ST_DONE_I = ST_DONE_I_ENC,
        ST_DONE_D = ST_DONE_D_ENC
    } fill_state_e;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/cache_fill_ctrl_fill_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fill_counter
// Purpose  : Up-counter with synchronous clear and count enable. Used for the
//            request and response word counters of the fill controller.
// Ports    : clk    - clock
//            rst_n  - synchronous active-low reset (clears the count)
//            clr    - synchronous clear, has priority over en
//            en     - increment enable
//            count  - current count value
// Revision : 1.0  initial release
// ============================================================================
module fill_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : fill_counter
`default_nettype wire

// File: rtl/cache_fill_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cache_fill_ctrl
// Purpose  : Miss-handling controller shared by the I-cache and D-cache. On a
//            miss it streams the 8-word block from main memory (one request
//            per cycle), writes each returned word into the requesting cache's
//            data array, writes the tag with the last word, and stalls the
//            pipeline side until the fill completes. D-cache wins ties.
// Ports    : clk, rst_n              - clock, synchronous active-low reset
//            i_miss/i_miss_addr      - I-cache miss request and byte address
//            d_miss/d_miss_addr      - D-cache miss request and byte address
//            mem_rd_en/mem_addr      - memory read request (one word/cycle)
//            mem_data_valid/mem_data - memory returned word
//            fill_data/fill_word     - word and word index to write
//            fill_base               - block-aligned address of active fill
//            i_fill_we/d_fill_we     - data-array write enables
//            i_tag_we/d_tag_we       - tag write + valid set
//            i_busy/d_busy           - pipeline stall per cache
// Revision : 1.0  initial release
// ============================================================================
module cache_fill_ctrl #(
    parameter int BLOCK_WORDS = 8,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_miss,
    input  logic [ADDR_W-1:0]              i_miss_addr,
    input  logic                           d_miss,
    input  logic [ADDR_W-1:0]              d_miss_addr,
    output logic                           mem_rd_en,
    output logic [ADDR_W-1:0]              mem_addr,
    input  logic                           mem_data_valid,
    input  logic [DATA_W-1:0]              mem_data,
    output logic [DATA_W-1:0]              fill_data,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
    output logic [ADDR_W-1:0]              fill_base,
    output logic                           i_fill_we,
    output logic                           d_fill_we,
    output logic                           i_tag_we,
    output logic                           d_tag_we,
    output logic                           i_busy,
    output logic                           d_busy
);

    import cache_pkg::*;

    localparam int                IDX_W     = $clog2(BLOCK_WORDS);
    // Request counter is one bit wider so it can sit at BLOCK_WORDS once all
    // requests have gone out.
    localparam logic [IDX_W:0]    REQ_END   = (IDX_W+1)'(BLOCK_WORDS);
    localparam logic [IDX_W-1:0]  RSP_LAST  = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(2 * BLOCK_WORDS - 1));

    fill_state_e       state_q;
    fill_state_e       state_d;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] base_d;

    logic [IDX_W:0]    req_cnt;
    logic [IDX_W-1:0]  rsp_cnt;

    logic              in_fill;
    logic              req_active;
    logic              rsp_fire;
    logic              rsp_last;
    logic              arb_state;
    logic              take_d;
    logic              take_i;
    logic              start;
    logic [ADDR_W-1:0] word_off;

    assign in_fill    = (state_q == ST_FILL_I) || (state_q == ST_FILL_D);
    assign req_active = in_fill && (req_cnt < REQ_END);
    assign rsp_fire   = in_fill && mem_data_valid;
    assign rsp_last   = rsp_fire && (rsp_cnt == RSP_LAST);

    // The side that just finished is still holding its miss line for one
    // cycle (its tag is written but the cache only hits next cycle), so it
    // is excluded from arbitration while in its DONE state.
    assign arb_state  = (state_q == ST_IDLE)   ||
                        (state_q == ST_DONE_I) ||
                        (state_q == ST_DONE_D);
    assign take_d     = arb_state && d_miss && (state_q != ST_DONE_D);
    assign take_i     = arb_state && i_miss && (state_q != ST_DONE_I) && !take_d;
    assign start      = take_d || take_i;

    // ------------------------------------------------------------------
    // Next-state / base-address logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        case (state_q)
            ST_FILL_I: begin
                if (rsp_last) begin
                    state_d = ST_DONE_I;
                end
            end
            ST_FILL_D: begin
                if (rsp_last) begin
                    state_d = ST_DONE_D;
                end
            end
            default: begin
                if (take_d) begin
                    state_d = ST_FILL_D;
                    base_d  = d_miss_addr & ADDR_MASK;
                end else if (take_i) begin
                    state_d = ST_FILL_I;
                    base_d  = i_miss_addr & ADDR_MASK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
        end
    end

    // ------------------------------------------------------------------
    // Word counters: requests issued and responses written
    // ------------------------------------------------------------------
    fill_counter #(
        .WIDTH (IDX_W + 1)
    ) u_req_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .en    (req_active),
        .count (req_cnt)
    );

    fill_counter #(
        .WIDTH (IDX_W)
    ) u_rsp_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .en    (rsp_fire),
        .count (rsp_cnt)
    );

    // ------------------------------------------------------------------
    // Outputs. Everything is forced low while rst_n is asserted, since the
    // state registers only clear on the following edge.
    // ------------------------------------------------------------------
    // base is block aligned, so the word offset never carries out of the
    // block: the top block ends at base + 14 with no wrap.
    assign word_off  = {{(ADDR_W-IDX_W-1){1'b0}}, req_cnt[IDX_W-1:0], 1'b0};

    assign mem_rd_en = rst_n && req_active;
    assign mem_addr  = mem_rd_en ? (base_q + word_off) : '0;

    assign fill_data = rst_n ? mem_data : '0;
    assign fill_word = (rst_n && in_fill) ? rsp_cnt : '0;
    assign fill_base = (rst_n && in_fill) ? base_q : '0;

    assign i_fill_we = rst_n && (state_q == ST_FILL_I) && mem_data_valid;
    assign d_fill_we = rst_n && (state_q == ST_FILL_D) && mem_data_valid;
    assign i_tag_we  = i_fill_we && (rsp_cnt == RSP_LAST);
    assign d_tag_we  = d_fill_we && (rsp_cnt == RSP_LAST);

    assign i_busy    = rst_n && ((state_q == ST_FILL_I) ||
                                 (i_miss && (state_q != ST_DONE_I)));
    assign d_busy    = rst_n && ((state_q == ST_FILL_D) ||
                                 (d_miss && (state_q != ST_DONE_D)));

endmodule : cache_fill_ctrl
`default_nettype wire

// File: tb/tb_cache_fill_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cache_fill_ctrl
// Purpose  : Self-checking bench for cache_fill_ctrl. A 4-cycle memory model
//            answers the DUT's requests; a transaction-level model of the
//            fill sequence predicts every output each cycle. Directed
//            scenarios plus randomized miss/reset/spurious-valid traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_cache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_miss = 1'b0;
    logic        d_miss = 1'b0;
    logic [15:0] i_miss_addr = 16'h0;
    logic [15:0] d_miss_addr = 16'h0;
    logic        mem_data_valid = 1'b0;
    logic [15:0] mem_data = 16'h0;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic [15:0] fill_base;
    logic        i_fill_we, d_fill_we, i_tag_we, d_tag_we, i_busy, d_busy;

    cache_fill_ctrl #(
        .BLOCK_WORDS (8),
        .ADDR_W      (16),
        .DATA_W      (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_miss         (i_miss),
        .i_miss_addr    (i_miss_addr),
        .d_miss         (d_miss),
        .d_miss_addr    (d_miss_addr),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_data_valid (mem_data_valid),
        .mem_data       (mem_data),
        .fill_data      (fill_data),
        .fill_word      (fill_word),
        .fill_base      (fill_base),
        .i_fill_we      (i_fill_we),
        .d_fill_we      (d_fill_we),
        .i_tag_we       (i_tag_we),
        .d_tag_we       (d_tag_we),
        .i_busy         (i_busy),
        .d_busy         (d_busy)
    );

    always #5 clk = ~clk;

    // Counters (written only by the compare process)
    int checks = 0;
    int errors = 0;

    // Cycle number (written only by the driver)
    int cyc = 0;
    bit spur = 1'b0;

    // Memory pipeline: slot for the cycle in which the word comes back
    bit          pipe_v [16];
    logic [15:0] pipe_a [16];

    // Transaction model: side 0 none, 1 I, 2 D
    int          m_side = 0;
    int          m_done = 0;
    int          m_k = 0;
    int          m_words = 0;
    logic [15:0] m_base = 16'h0;

    // Event log of observed DUT behaviour, used by literal checks
    int          first_rd_cyc = -100;
    logic [15:0] first_addr = 16'h0;
    logic [15:0] last_addr = 16'h0;
    logic [2:0]  first_word = 3'd0;
    int          wr_seen = 0;
    int          d_tag_cyc = -100;
    int          i_tag_cyc = -100;
    int          d_we_cnt = 0;
    logic        dbusy_after = 1'b1;
    bit          prev_rd = 1'b0;

    // Literal-check mailbox from the driver to the compare process
    string       lit_name [64];
    logic [15:0] lit_act [64];
    logic [15:0] lit_exp [64];
    int          lit_n = 0;
    int          lit_done = 0;

    // Expected outputs for the current cycle
    logic        e_rd, e_ifwe, e_dfwe, e_itag, e_dtag, e_ibusy, e_dbusy;
    logic [15:0] e_addr, e_base;

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Compare process: predict, check, feed memory, advance model
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        while (lit_done < lit_n) begin
            chk(lit_name[lit_done], lit_act[lit_done], lit_exp[lit_done]);
            lit_done++;
        end

        e_rd = 0; e_addr = 0; e_ifwe = 0; e_dfwe = 0; e_itag = 0; e_dtag = 0;
        e_base = 0; e_ibusy = 0; e_dbusy = 0;
        if (rst_n) begin
            e_ibusy = (m_side == 1) || (i_miss && m_done != 1);
            e_dbusy = (m_side == 2) || (d_miss && m_done != 2);
            if (m_side != 0) begin
                e_base = m_base;
                e_rd   = (m_k < 8);
                if (e_rd) e_addr = m_base + 16'(2 * m_k);
                if (mem_data_valid) begin
                    if (m_side == 1) e_ifwe = 1; else e_dfwe = 1;
                    if (m_words == 7) begin
                        if (m_side == 1) e_itag = 1; else e_dtag = 1;
                    end
                end
            end
        end

        chk("mem_rd_en", {15'b0, mem_rd_en}, {15'b0, e_rd});
        chk("mem_addr", mem_addr, e_addr);
        chk("fill_base", fill_base, e_base);
        chk("i_fill_we", {15'b0, i_fill_we}, {15'b0, e_ifwe});
        chk("d_fill_we", {15'b0, d_fill_we}, {15'b0, e_dfwe});
        chk("i_tag_we", {15'b0, i_tag_we}, {15'b0, e_itag});
        chk("d_tag_we", {15'b0, d_tag_we}, {15'b0, e_dtag});
        chk("i_busy", {15'b0, i_busy}, {15'b0, e_ibusy});
        chk("d_busy", {15'b0, d_busy}, {15'b0, e_dbusy});
        if (!rst_n) begin
            chk("fill_data_rst", fill_data, 16'h0);
            chk("fill_word_rst", {13'b0, fill_word}, 16'h0);
        end else if (e_ifwe || e_dfwe) begin
            chk("fill_word", {13'b0, fill_word}, 16'(m_words));
            chk("fill_data", fill_data, mdata(m_base + 16'(2 * m_words)));
        end

        // observation log
        if (mem_rd_en && !prev_rd) begin
            first_rd_cyc = cyc;
            first_addr   = mem_addr;
            wr_seen      = 0;
        end
        if (mem_rd_en) last_addr = mem_addr;
        prev_rd = mem_rd_en;
        if (d_fill_we || i_fill_we) begin
            if (wr_seen == 0) first_word = fill_word;
            wr_seen++;
        end
        if (d_fill_we) d_we_cnt++;
        if (d_tag_we) d_tag_cyc = cyc;
        if (i_tag_we) i_tag_cyc = cyc;
        if (cyc == d_tag_cyc + 1) dbusy_after = d_busy;

        // memory: this cycle's slot is consumed; reset discards everything
        pipe_v[cyc % 16] = 1'b0;
        if (!rst_n) begin
            for (int j = 0; j < 16; j++) pipe_v[j] = 1'b0;
        end else if (mem_rd_en) begin
            pipe_v[(cyc + 4) % 16] = 1'b1;
            pipe_a[(cyc + 4) % 16] = mem_addr;
        end

        // model advance
        if (!rst_n) begin
            m_side = 0;
            m_done = 0;
        end else if (m_side != 0) begin
            m_k++;
            if (mem_data_valid) begin
                if (m_words == 7) begin
                    m_done = m_side;
                    m_side = 0;
                end
                m_words++;
            end
        end else begin
            if (d_miss && m_done != 2) begin
                m_side = 2;
                m_base = d_miss_addr & 16'hFFF0;
            end else if (i_miss && m_done != 1) begin
                m_side = 1;
                m_base = i_miss_addr & 16'hFFF0;
            end
            m_k     = 0;
            m_words = 0;
            m_done  = 0;
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic lit(input string nm, input logic [15:0] a, input logic [15:0] e);
        if (lit_n < 64) begin
            lit_name[lit_n] = nm;
            lit_act[lit_n]  = a;
            lit_exp[lit_n]  = e;
            lit_n++;
        end
    endtask

    // Advance one cycle; present memory response; model the caches
    // releasing their miss the cycle after the tag write.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        mem_data_valid = pipe_v[cyc % 16] | spur;
        mem_data = pipe_v[cyc % 16] ? mdata(pipe_a[cyc % 16]) : 16'($urandom);
        if (d_miss && (d_tag_cyc == cyc - 2)) d_miss = 1'b0;
        if (i_miss && (i_tag_cyc == cyc - 2)) i_miss = 1'b0;
    endtask

    task automatic wait_tag(input bit dside, input int limit);
        int t0;
        int n;
        t0 = dside ? d_tag_cyc : i_tag_cyc;
        n = 0;
        while (((dside ? d_tag_cyc : i_tag_cyc) == t0) && (n < limit)) begin
            step();
            n++;
        end
        if ((dside ? d_tag_cyc : i_tag_cyc) == t0) lit("timeout_tag", 16'd0, 16'd1);
    endtask

    initial begin
        int c0;
        int dt;
        int w0;
        int n;

        // reset
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // lone D miss
        d_miss = 1'b1; d_miss_addr = 16'h1236; c0 = cyc;
        wait_tag(1'b1, 40);
        repeat (2) step();
        lit("lone_first_cyc", 16'(first_rd_cyc - c0), 16'd1);
        lit("lone_first_addr", first_addr, 16'h1230);
        lit("lone_last_addr", last_addr, 16'h123E);
        lit("lone_tag_offset", 16'(d_tag_cyc - first_rd_cyc), 16'd11);
        lit("lone_busy_done", {15'b0, dbusy_after}, 16'd0);
        repeat (3) step();

        // simultaneous misses, D first
        i_miss = 1'b1; i_miss_addr = 16'h0044;
        d_miss = 1'b1; d_miss_addr = 16'h2000;
        wait_tag(1'b1, 40);
        dt = d_tag_cyc;
        lit("simul_d_addr", first_addr, 16'h2000);
        wait_tag(1'b0, 40);
        lit("simul_i_addr", first_addr, 16'h0040);
        lit("simul_i_start", 16'(first_rd_cyc - dt), 16'd2);
        repeat (3) step();

        // reset after the third D write
        d_miss = 1'b1; d_miss_addr = 16'h1236;
        w0 = d_we_cnt; n = 0;
        while ((d_we_cnt < w0 + 3) && (n < 40)) begin step(); n++; end
        if (d_we_cnt < w0 + 3) lit("timeout_we", 16'd0, 16'd1);
        rst_n = 1'b0; d_miss = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        d_miss = 1'b1; d_miss_addr = 16'h1236; c0 = cyc;
        wait_tag(1'b1, 40);
        step();
        lit("rst_restart_cyc", 16'(first_rd_cyc - c0), 16'd1);
        lit("rst_restart_addr", first_addr, 16'h1230);
        lit("rst_restart_word", {13'b0, first_word}, 16'd0);
        repeat (3) step();

        // top-of-memory block
        i_miss = 1'b1; i_miss_addr = 16'hFFFE;
        wait_tag(1'b0, 40);
        lit("top_first_addr", first_addr, 16'hFFF0);
        lit("top_last_addr", last_addr, 16'hFFFE);
        repeat (3) step();

        // spurious valid while idle, then confirm a miss starts next cycle
        spur = 1'b1;
        repeat (3) step();
        spur = 1'b0;
        step();
        d_miss = 1'b1; d_miss_addr = 16'h0A1C; c0 = cyc;
        wait_tag(1'b1, 40);
        lit("spur_idle_start", 16'(first_rd_cyc - c0), 16'd1);
        repeat (3) step();

        // miss dropped in fill cycle 5
        d_miss = 1'b1; d_miss_addr = 16'h1236; c0 = cyc;
        repeat (6) step();
        d_miss = 1'b0;
        wait_tag(1'b1, 40);
        lit("drop_first_cyc", 16'(first_rd_cyc - c0), 16'd1);
        lit("drop_tag_offset", 16'(d_tag_cyc - first_rd_cyc), 16'd11);
        repeat (3) step();

        // randomized traffic
        for (int r = 0; r < 3000; r++) begin
            step();
            if (!d_miss && $urandom_range(0, 15) == 0) begin
                d_miss = 1'b1; d_miss_addr = 16'($urandom);
            end else if (d_miss && $urandom_range(0, 31) == 0) begin
                d_miss_addr = 16'($urandom);
            end
            if (!i_miss && $urandom_range(0, 15) == 0) begin
                i_miss = 1'b1; i_miss_addr = 16'($urandom);
            end else if (i_miss && $urandom_range(0, 31) == 0) begin
                i_miss_addr = 16'($urandom);
            end
            if (d_miss && m_side == 2 && $urandom_range(0, 63) == 0) d_miss = 1'b0;
            if (!mem_data_valid && m_side == 0 && $urandom_range(0, 7) == 0) mem_data_valid = 1'b1;
            rst_n = ($urandom_range(0, 499) != 0);
        end

        rst_n = 1'b1; i_miss = 1'b0; d_miss = 1'b0;
        repeat (20) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_cache_fill_ctrl
`default_nettype wire

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
- Miss-handling controller between the I-cache and D-cache and the shared 4-cycle-latency main memory, for the pipelined WISC CPU.
- On a cache miss it reads the 16-byte block (8 words) from memory and writes each returned word into the requesting cache's data array.
- It then writes the tag, and holds the pipeline stall (busy) until the fill completes.
- Arbitrates between the two caches; D-cache has priority.

Parameters:
- BLOCK_WORDS, 8, 16-bit words per cache block.
- ADDR_W, 16, byte-address width.
- DATA_W, 16, memory/cache data width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_miss  in  1  I-cache miss; held high by the cache until the cycle after i_tag_we
- i_miss_addr  in  16  I-cache miss byte address
- d_miss  in  1  D-cache miss; same hold rule as i_miss
- d_miss_addr  in  16  D-cache miss byte address
- mem_rd_en  out  1  memory read request, one word per cycle
- mem_addr  out  16  memory request byte address
- mem_data_valid  in  1  memory returned word valid (4 cycles after its request)
- mem_data  in  16  memory returned word
- fill_data  out  16  word to write into the cache data array (= mem_data, combinational)
- fill_word  out  3  word index within the block for the current write
- fill_base  out  16  block-aligned address of the active fill (used for tag/index)
- i_fill_we, d_fill_we  out  1  data-array write enable, per cache
- i_tag_we, d_tag_we  out  1  tag-array write plus valid set, per cache
- i_busy, d_busy  out  1  stall to the pipeline, per cache

Behaviour:
- States: IDLE, FILL_I, FILL_D, DONE_I, DONE_D.
- Registers: req_cnt (4b), rsp_cnt (3b), base (16b).
- Reset (rst_n low at a clk edge):
  - State goes to IDLE; counters and base clear to 0.
  - Memory shares rst_n, so responses outstanding before reset are discarded.
  - All outputs are 0 while rst_n is low, including busy and fill_data.
- Arbitration:
  - Performed in IDLE, and in DONE_x ignoring side x.
  - d_miss wins over i_miss.
  - Winner: base <= miss_addr & 16'hFFF0; counters clear; next state FILL_x.
  - In DONE_x with no other miss pending, next state is IDLE.
- FILL_x, request side:
  - mem_rd_en = 1 while req_cnt < 8.
  - mem_addr = base + {req_cnt[2:0], 1'b0}.
  - req_cnt increments each cycle while < 8.
  - Requests are issued in FILL cycles 0..7.
- FILL_x, response side:
  - Each mem_data_valid asserts x_fill_we with fill_word = rsp_cnt; rsp_cnt then increments.
  - With latency 4, words arrive in FILL cycles 4..11.
- FILL_x, completion: when mem_data_valid and rsp_cnt == 7, x_tag_we = 1 that cycle, then go to DONE_x. Total fill is 12 cycles.
- mem_addr is 0 whenever mem_rd_en = 0.
- fill_base = base in FILL states, otherwise 0.
- Busy:
  - x_busy = 1 in FILL_x.
  - x_busy = 1 when x_miss is high in any state other than DONE_x.
  - In DONE_x, x_busy = 0 (the cache hits next cycle).
- mem_data_valid outside FILL states: ignored, no writes.
- A miss dropped mid-fill does not abort; the fill completes.
- A miss address change mid-fill is ignored because base is latched.
- Address arithmetic stays within the block; no wrap past base + 14.

Decomposition:
- Shared package `cache_pkg`:
  - BLOCK_WORDS, BLOCK_MASK (16'hFFF0).
  - State encoding localparams.
  - MEM_LATENCY (4), for benches only.
- One natural sub-module, `fill_counter`:
  - Parameterised width; sync clear and enable.
  - Instantiated for req_cnt and rsp_cnt.

Test Plan:
- Lone D miss:
  - Stimulus: d_miss = 1, d_miss_addr = 0x1236, against a 4-cycle memory model.
  - Requests: mem_addr 0x1230, 0x1232, …, 0x123E in FILL cycles 0..7.
  - Writes: d_fill_we in cycles 4..11 with fill_word 0..7; d_tag_we in cycle 11.
  - Release: d_busy low in the DONE_D cycle.
- Simultaneous misses:
  - Stimulus: i_miss at 0x0044 and d_miss at 0x2000 in the same cycle.
  - D fill (base 0x2000) runs first with i_busy high throughout.
  - I fill's first mem_addr 0x0040 appears 2 cycles after d_tag_we (DONE_D goes straight to FILL_I).
- Reset mid-fill:
  - Stimulus: rst_n low after the 3rd d_fill_we.
  - Next cycle: all outputs 0, state IDLE.
  - After reset, a re-raised miss at 0x1236 restarts from mem_addr 0x1230, fill_word 0.
- Top-of-memory block:
  - Stimulus: miss at 0xFFFE.
  - Required: base 0xFFF0, last request 0xFFFE, no address wrap to 0x0000.
- Spurious valid:
  - Stimulus: mem_data_valid pulses in IDLE.
  - Required: no fill_we or tag_we; state stays IDLE.
- Miss drop:
  - Stimulus: d_miss deasserted in FILL cycle 5.
  - Required: remaining words and d_tag_we are still written, in cycle 11.
